// File: rtl/arb_pkg.sv
// Shared types and defaults for the memory bus arbiter.
//   arb_state_e  : arbiter FSM states
//   owner_idx_t  : master index, wide enough for the largest supported master count
//   wrap_inc     : index increment with wrap-around at a run-time master count
package arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StOwned
  } arb_state_e;

  localparam int unsigned DefTimeout = 16;
  localparam int unsigned DefMaxHold = 8;
  localparam int unsigned MaxMasters = 8;
  localparam int unsigned OwnerW     = $clog2(MaxMasters);

  typedef logic [OwnerW-1:0] owner_idx_t;

  function automatic owner_idx_t wrap_inc(owner_idx_t idx, int unsigned n);
    if (32'(idx) + 32'd1 >= n) begin
      return '0;
    end
    return idx + owner_idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
//   req_i        : per-master request vector
//   last_owner_i : index of the most recent owner; the search starts just after it
//   valid_o      : at least one request is present
//   winner_o     : index of the first requester found, wrapping around
module rr_picker
  import arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [OwnerW-1:0]      last_owner_i,
  output logic                   valid_o,
  output logic [OwnerW-1:0]      winner_o
);

  owner_idx_t idx;

  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = last_owner_i;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx = wrap_inc(idx, NUM_MASTERS);
      // Select req bit by comparison to keep index widths exact.
      for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
        if (!valid_o && (owner_idx_t'(j) == idx) && req_i[j]) begin
          valid_o  = 1'b1;
          winner_o = idx;
        end
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one external memory bus between NUM_MASTERS masters.
//   req/lock       : per-master bus request and burst lock (lock sampled only at ack)
//   m_rd/m_wr      : per-master strobes; m_addr/m_wdata packed, master i at slice i
//   gnt            : registered one-hot grant
//   ack            : combinational transfer-complete pulse to the owner
//   rdata          : read data shared by all masters, zero unless a read is acked
//   bus_err        : one-cycle pulse on timeout or simultaneous rd+wr
//   mem_*          : memory-side strobes, address, write data, read data and ack
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_HOLD    = DefMaxHold,
  parameter int unsigned TIMEOUT     = DefTimeout
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            req,
  input  logic [NUM_MASTERS-1:0]            lock,
  input  logic [NUM_MASTERS-1:0]            m_rd,
  input  logic [NUM_MASTERS-1:0]            m_wr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            gnt,
  output logic [NUM_MASTERS-1:0]            ack,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              bus_err,
  output logic                              mem_rd,
  output logic                              mem_wr,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  input  logic                              mem_ack
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam int unsigned ToW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_e             state_q, state_d;
  owner_idx_t             owner_q, owner_d;
  owner_idx_t             last_q, last_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic [ToW-1:0]         to_q, to_d;

  logic                   pick_valid;
  owner_idx_t             pick_idx;

  logic                   own_rd, own_wr, own_req, own_lock;
  logic [ADDR_WIDTH-1:0]  own_addr;
  logic [DATA_WIDTH-1:0]  own_wdata;
  logic                   owned, cur_rd, cur_wr;
  logic                   strobe, illegal, done_ok, tmo, ack_any;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_picker (
    .req_i        (req),
    .last_owner_i (last_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_idx)
  );

  // Owner's view of its inputs.
  always_comb begin
    own_rd    = 1'b0;
    own_wr    = 1'b0;
    own_req   = 1'b0;
    own_lock  = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (owner_q == owner_idx_t'(i)) begin
        own_rd    = m_rd[i];
        own_wr    = m_wr[i];
        own_req   = req[i];
        own_lock  = lock[i];
        own_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign owned   = (state_q == StOwned);
  assign cur_rd  = owned & own_rd;
  assign cur_wr  = owned & own_wr;
  assign illegal = cur_rd & cur_wr;
  assign strobe  = cur_rd ^ cur_wr;
  assign done_ok = strobe & mem_ack;
  // On the last allowed cycle a real ack still wins over the abort.
  assign tmo     = strobe & ~mem_ack & (to_q == ToW'(TIMEOUT - 1));
  assign ack_any = done_ok | tmo | illegal;

  assign mem_rd    = cur_rd & ~cur_wr & ~tmo;
  assign mem_wr    = cur_wr & ~cur_rd & ~tmo;
  assign mem_addr  = owned ? own_addr : '0;
  assign mem_wdata = owned ? own_wdata : '0;
  assign rdata     = (done_ok && cur_rd) ? mem_rdata : '0;
  assign bus_err   = tmo | illegal;
  assign gnt       = gnt_q;

  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      ack[i] = ack_any && (owner_q == owner_idx_t'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    to_d    = to_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StOwned;
          owner_d = pick_idx;
          hold_d  = '0;
          to_d    = '0;
          for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            gnt_d[i] = (pick_idx == owner_idx_t'(i));
          end
        end
      end
      StOwned: begin
        to_d = (strobe && !mem_ack) ? to_q + ToW'(1) : '0;
        if (done_ok) begin
          hold_d = hold_q + HoldW'(1);
          if (!(own_lock && own_req && (hold_q + HoldW'(1) < HoldW'(MAX_HOLD)))) begin
            state_d = StIdle;
            gnt_d   = '0;
            last_d  = owner_q;
            to_d    = '0;
          end
        end else if (tmo || illegal || (!own_req && !strobe)) begin
          state_d = StIdle;
          gnt_d   = '0;
          last_d  = owner_q;
          to_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= owner_idx_t'(NUM_MASTERS - 1);
      gnt_q   <= '0;
      hold_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: two masters, MAX_HOLD=4, TIMEOUT=16.
module tb_mem_bus_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NM-1:0]  req, lock, m_rd, m_wr;
  logic [AW-1:0]  m_addr0, m_addr1;
  logic [DW-1:0]  m_wdata0, m_wdata1;
  logic [NM-1:0]  gnt, ack;
  logic [DW-1:0]  rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]  mem_addr;
  logic           bus_err, mem_rd, mem_wr, mem_ack;

  int checks = 0;
  int errors = 0;

  logic [1:0] rr_exp [8];

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MAX_HOLD    (4),
    .TIMEOUT     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .m_rd      (m_rd),
    .m_wr      (m_wr),
    .m_addr    ({m_addr1, m_addr0}),
    .m_wdata   ({m_wdata1, m_wdata0}),
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .bus_err   (bus_err),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next cycle: inputs change just after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst_n released at a falling edge with all inputs idle.
  task automatic do_reset();
    req       = '0;
    lock      = '0;
    m_rd      = '0;
    m_wr      = '0;
    m_addr0   = '0;
    m_addr1   = '0;
    m_wdata0  = '0;
    m_wdata1  = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rr_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    // Reset state
    do_reset();
    check_eq("rst_gnt", 64'(gnt), 64'h0);
    check_eq("rst_ack", 64'(ack), 64'h0);
    check_eq("rst_err", 64'(bus_err), 64'h0);
    check_eq("rst_strobes", 64'({mem_rd, mem_wr}), 64'h0);
    check_eq("rst_addr", 64'(mem_addr), 64'h0);
    check_eq("rst_wdata", 64'(mem_wdata), 64'h0);
    check_eq("rst_rdata", 64'(rdata), 64'h0);

    // 1. Single read, ack at cycle 3
    req = 2'b01;
    next_cycle();
    m_rd = 2'b01;
    m_addr0 = 32'h100;
    @(negedge clk);
    check_eq("rd_gnt_c1", 64'(gnt), 64'h1);
    check_eq("rd_addr", 64'(mem_addr), 64'h100);
    check_eq("rd_strobe", 64'(mem_rd), 64'h1);
    next_cycle();
    @(negedge clk);
    check_eq("rd_noack_c2", 64'(ack), 64'h0);
    next_cycle();
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("rd_ack_c3", 64'(ack), 64'h1);
    check_eq("rd_rdata_c3", 64'(rdata), 64'hDEADBEEF);
    check_eq("rd_err_c3", 64'(bus_err), 64'h0);
    next_cycle();
    mem_ack = 1'b0;
    m_rd = '0;
    req = '0;
    @(negedge clk);
    check_eq("rd_gnt_c4", 64'(gnt), 64'h0);

    // 2. Contention, every transfer acked immediately
    do_reset();
    req = 2'b11;
    m_rd = 2'b11;
    mem_ack = 1'b1;
    mem_rdata = 32'h5A5A5A5A;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      @(negedge clk);
      check_eq($sformatf("rr_gnt_%0d", i), 64'(gnt), 64'(rr_exp[i]));
      check_eq($sformatf("rr_ack_%0d", i), 64'(ack), 64'(rr_exp[i]));
    end

    // 3. Locked burst by master 1 capped at 4 acks
    do_reset();
    req = 2'b10;
    lock = 2'b10;
    m_wr = 2'b10;
    m_wdata1 = 32'hCAFE0001;
    mem_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      if (i == 1) begin
        req = 2'b11;
        m_rd = 2'b01;
      end
      @(negedge clk);
      check_eq($sformatf("lk_gnt_%0d", i), 64'(gnt), 64'h2);
      check_eq($sformatf("lk_ack_%0d", i), 64'(ack), 64'h2);
    end
    check_eq("lk_wdata", 64'(mem_wdata), 64'hCAFE0001);
    next_cycle();
    @(negedge clk);
    check_eq("lk_idle_gnt", 64'(gnt), 64'h0);
    check_eq("lk_idle_ack", 64'(ack), 64'h0);
    next_cycle();
    @(negedge clk);
    check_eq("lk_m0_gnt", 64'(gnt), 64'h1);
    check_eq("lk_m0_ack", 64'(ack), 64'h1);
    next_cycle();
    req = 2'b10;
    m_rd = '0;
    @(negedge clk);
    check_eq("lk_idle2_gnt", 64'(gnt), 64'h0);
    next_cycle();
    @(negedge clk);
    check_eq("lk_regrant", 64'(gnt), 64'h2);

    // 4. Timeout after 16 strobe cycles
    do_reset();
    req = 2'b01;
    mem_rdata = 32'h12345678;
    next_cycle();
    m_rd = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) next_cycle();
      @(negedge clk);
      if (k < 16) begin
        check_eq($sformatf("tmo_wait_%0d", k), 64'({ack, bus_err}), 64'h0);
      end else begin
        check_eq("tmo_ack", 64'(ack), 64'h1);
        check_eq("tmo_err", 64'(bus_err), 64'h1);
        check_eq("tmo_rdata", 64'(rdata), 64'h0);
      end
    end
    next_cycle();
    @(negedge clk);
    check_eq("tmo_rd_drop", 64'(mem_rd), 64'h0);
    check_eq("tmo_gnt_rel", 64'(gnt), 64'h0);
    check_eq("tmo_err_pulse", 64'(bus_err), 64'h0);

    // 5. Illegal rd+wr from master 1
    do_reset();
    req = 2'b10;
    mem_rdata = 32'h87654321;
    next_cycle();
    m_rd = 2'b10;
    m_wr = 2'b10;
    mem_ack = 1'b1;
    @(negedge clk);
    check_eq("ill_gnt", 64'(gnt), 64'h2);
    check_eq("ill_strobes", 64'({mem_rd, mem_wr}), 64'h0);
    check_eq("ill_err", 64'(bus_err), 64'h1);
    check_eq("ill_ack", 64'(ack), 64'h2);
    check_eq("ill_rdata", 64'(rdata), 64'h0);
    next_cycle();
    @(negedge clk);
    check_eq("ill_release", 64'(gnt), 64'h0);

    // 6. Reset in the middle of a write
    do_reset();
    req = 2'b01;
    next_cycle();
    m_wr = 2'b01;
    @(negedge clk);
    check_eq("rm_wr_active", 64'(mem_wr), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rm_wr_drop", 64'(mem_wr), 64'h0);
    check_eq("rm_gnt_drop", 64'(gnt), 64'h0);
    check_eq("rm_no_ack", 64'(ack), 64'h0);
    @(posedge clk);
    @(negedge clk);
    m_wr = '0;
    req = 2'b11;
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check_eq("rm_first_m0", 64'(gnt), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
